// File: rtl/stream_gearbox.sv
// rtl/stream_gearbox.sv - LSB-first streaming width converter with flush-driven zero-padded drain
// Packs IN_NBITS words into a right-aligned bit buffer and emits OUT_NBITS words under val/rdy.
module stream_gearbox #(
  parameter int IN_NBITS  = 3,
  parameter int OUT_NBITS = 4,
  parameter int BUF_NBITS = IN_NBITS + OUT_NBITS,
  localparam int CNT_W    = $clog2(BUF_NBITS + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_val,
  output logic                 in_rdy,
  input  logic [IN_NBITS-1:0]  in_msg,
  output logic                 out_val,
  input  logic                 out_rdy,
  output logic [OUT_NBITS-1:0] out_msg,
  input  logic                 flush,
  output logic [CNT_W-1:0]     count
);

  typedef logic [CNT_W:0] ext_t;

  localparam ext_t              OUT_E = ext_t'(OUT_NBITS);
  localparam ext_t              IN_E  = ext_t'(IN_NBITS);
  localparam ext_t              BUF_E = ext_t'(BUF_NBITS);
  localparam logic [CNT_W-1:0]  OUT_C = CNT_W'(OUT_NBITS);
  localparam logic [CNT_W-1:0]  IN_C  = CNT_W'(IN_NBITS);

  logic [BUF_NBITS-1:0] data_q, data_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 flush_pend_q, flush_pend_d;

  logic [CNT_W-1:0]     deq_bits;
  logic [CNT_W-1:0]     base;
  logic                 deq;
  logic                 enq;
  ext_t                 cnt_e;
  ext_t                 fill_e;
  logic [BUF_NBITS-1:0] shifted;
  logic [BUF_NBITS-1:0] in_ext;

  always_comb begin
    cnt_e   = ext_t'(count_q);
    out_val = (cnt_e >= OUT_E) | (flush_pend_q & (count_q != '0));
    for (int i = 0; i < OUT_NBITS; i++) begin
      out_msg[i] = data_q[i] & (ext_t'(i) < cnt_e);
    end

    deq_bits = (cnt_e < OUT_E) ? count_q : OUT_C;
    deq      = out_val & out_rdy;
    base     = deq ? (count_q - deq_bits) : count_q;

    // Space check sees this cycle's dequeue, so a full buffer can still take a word.
    fill_e = ext_t'(base) + IN_E;
    in_rdy = ~flush_pend_q & (fill_e <= BUF_E);
    enq    = in_val & in_rdy;

    // Bits at or above count are always zero, so OR-ing the new word in is enough.
    shifted = deq ? (data_q >> deq_bits) : data_q;
    in_ext  = {{(BUF_NBITS - IN_NBITS){1'b0}}, in_msg};
    data_d  = enq ? (shifted | (in_ext << base)) : shifted;
    count_d = enq ? (base + IN_C) : base;

    flush_pend_d = (flush_pend_q | flush) & (count_d != '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q       <= '0;
      count_q      <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      data_q       <= data_d;
      count_q      <= count_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  assign count = count_q;

endmodule

// File: tb/tb_stream_gearbox.sv
// tb/tb_stream_gearbox.sv - directed vector table on 3->4 plus scoreboarded random runs on 5->3, 8->8, 3->16
module tb_stream_gearbox;

  logic clk;
  logic rst_n;
  logic go;
  int   n_checks;
  int   n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  logic       d_in_val, d_in_rdy, d_out_val, d_out_rdy, d_flush;
  logic [2:0] d_in_msg;
  logic [3:0] d_out_msg;
  logic [2:0] d_count;

  stream_gearbox #(.IN_NBITS(3), .OUT_NBITS(4)) u_dut (
    .clk    (clk),
    .reset  (rst_n),
    .in_val (d_in_val),
    .in_rdy (d_in_rdy),
    .in_msg (d_in_msg),
    .out_val(d_out_val),
    .out_rdy(d_out_rdy),
    .out_msg(d_out_msg),
    .flush  (d_flush),
    .count  (d_count)
  );

  typedef struct {
    logic       iv;
    logic [2:0] im;
    logic       ordy;
    logic       fl;
    logic       e_ov;
    logic       e_ir;
    logic [3:0] e_om;
    logic [2:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic iv, input logic [2:0] im, input logic ordy, input logic fl,
                     input logic ov, input logic ir, input logic [3:0] om, input logic [2:0] cnt);
    vec_t v;
    v.iv = iv; v.im = im; v.ordy = ordy; v.fl = fl;
    v.e_ov = ov; v.e_ir = ir; v.e_om = om; v.e_cnt = cnt;
    vecs.push_back(v);
  endtask

  genvar g;
  generate
    for (g = 0; g < 3; g++) begin : g_rand
      localparam int IW = (g == 0) ? 5 : ((g == 1) ? 8 : 3);
      localparam int OW = (g == 0) ? 3 : ((g == 1) ? 8 : 16);
      localparam int BW = IW + OW;
      localparam int CW = $clog2(BW + 1);

      logic          r_iv, r_ir, r_ov, r_or, r_fl;
      logic [IW-1:0] r_im;
      logic [OW-1:0] r_om;
      logic [CW-1:0] r_cnt;
      logic          done;

      stream_gearbox #(.IN_NBITS(IW), .OUT_NBITS(OW)) u_dut (
        .clk    (clk),
        .reset  (rst_n),
        .in_val (r_iv),
        .in_rdy (r_ir),
        .in_msg (r_im),
        .out_val(r_ov),
        .out_rdy(r_or),
        .out_msg(r_om),
        .flush  (r_fl),
        .count  (r_cnt)
      );

      initial begin
        bit            q[$];
        bit            pend;
        int            sz, k;
        logic          e_ov, e_ir, deq;
        logic [OW-1:0] ew;
        r_iv = 1'b0; r_or = 1'b0; r_fl = 1'b0; r_im = '0;
        done = 1'b0;
        pend = 1'b0;
        wait (go);
        for (int c = 0; c < 800; c++) begin
          @(negedge clk);
          r_iv = ($urandom_range(0, 3) != 0);
          r_im = IW'($urandom);
          r_or = ($urandom_range(0, 2) != 0);
          r_fl = !r_fl && ($urandom_range(0, 15) == 0);
          #1;
          sz   = q.size();
          e_ov = (sz >= OW) || (pend && sz != 0);
          k    = (sz < OW) ? sz : OW;
          deq  = e_ov && r_or;
          e_ir = !pend && ((sz - (deq ? k : 0) + IW) <= BW);
          check($sformatf("rand%0d count", g), 32'(r_cnt), 32'(sz));
          check($sformatf("rand%0d out_val", g), 32'(r_ov), 32'(e_ov));
          check($sformatf("rand%0d in_rdy", g), 32'(r_ir), 32'(e_ir));
          if (deq) begin
            ew = '0;
            for (int i = 0; i < k; i++) ew[i] = q[i];
            check($sformatf("rand%0d out_msg", g), 32'(r_om), 32'(ew));
            for (int i = 0; i < k; i++) void'(q.pop_front());
          end
          if (e_ir && r_iv) begin
            for (int i = 0; i < IW; i++) q.push_back(r_im[i]);
          end
          pend = (pend || r_fl) && (q.size() != 0);
        end
        @(negedge clk);
        r_iv = 1'b0; r_or = 1'b0; r_fl = 1'b0;
        done = 1'b1;
      end
    end
  endgenerate

  initial begin
    n_checks = 0;
    n_fail   = 0;
    go       = 1'b0;
    rst_n    = 1'b0;
    d_in_val = 1'b0; d_in_msg = '0; d_out_rdy = 1'b0; d_flush = 1'b0;

    #3;
    check("reset out_val", 32'(d_out_val), 32'd0);
    check("reset in_rdy", 32'(d_in_rdy), 32'd1);
    check("reset out_msg", 32'(d_out_msg), 32'd0);
    check("reset count", 32'(d_count), 32'd0);

    for (int i = 0; i < 5; i++) add(0, 3'd0, 0, 0, 0, 1, 4'h0, 3'd0);
    // packing 101,011,110,001 -> d,9,3
    add(1, 3'b101, 1, 0, 0, 1, 4'h0, 3'd0);
    add(1, 3'b011, 1, 0, 0, 1, 4'h5, 3'd3);
    add(1, 3'b110, 1, 0, 1, 1, 4'hd, 3'd6);
    add(1, 3'b001, 1, 0, 1, 1, 4'h9, 3'd5);
    add(0, 3'd0,   1, 0, 1, 1, 4'h3, 3'd4);
    add(0, 3'd0,   1, 0, 0, 1, 4'h0, 3'd0);
    // flush of a partial word, input blocked while pending
    add(1, 3'b101, 0, 0, 0, 1, 4'h0, 3'd0);
    add(0, 3'd0,   0, 1, 0, 1, 4'h5, 3'd3);
    add(1, 3'b111, 0, 0, 1, 0, 4'h5, 3'd3);
    add(0, 3'd0,   1, 0, 1, 0, 4'h5, 3'd3);
    add(0, 3'd0,   0, 0, 0, 1, 4'h0, 3'd0);
    // flush together with an enqueue from empty
    add(1, 3'b110, 0, 1, 0, 1, 4'h0, 3'd0);
    add(0, 3'd0,   0, 0, 1, 0, 4'h6, 3'd3);
    add(0, 3'd0,   1, 0, 1, 0, 4'h6, 3'd3);
    add(0, 3'd0,   0, 0, 0, 1, 4'h0, 3'd0);
    // backpressure then simultaneous deq/enq
    add(1, 3'b111, 0, 0, 0, 1, 4'h0, 3'd0);
    add(1, 3'b111, 0, 0, 0, 1, 4'h7, 3'd3);
    add(1, 3'b111, 0, 0, 1, 0, 4'hf, 3'd6);
    add(1, 3'b111, 0, 0, 1, 0, 4'hf, 3'd6);
    add(1, 3'b111, 1, 0, 1, 1, 4'hf, 3'd6);
    add(0, 3'd0,   0, 0, 1, 0, 4'hf, 3'd5);
    add(0, 3'd0,   1, 0, 1, 1, 4'hf, 3'd5);
    add(0, 3'd0,   1, 1, 0, 1, 4'h1, 3'd1);
    add(0, 3'd0,   1, 0, 1, 0, 4'h1, 3'd1);
    add(0, 3'd0,   0, 0, 0, 1, 4'h0, 3'd0);

    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      d_in_val  = vecs[i].iv;
      d_in_msg  = vecs[i].im;
      d_out_rdy = vecs[i].ordy;
      d_flush   = vecs[i].fl;
      #1;
      check($sformatf("vec%0d out_val", i), 32'(d_out_val), 32'(vecs[i].e_ov));
      check($sformatf("vec%0d in_rdy", i), 32'(d_in_rdy), 32'(vecs[i].e_ir));
      check($sformatf("vec%0d out_msg", i), 32'(d_out_msg), 32'(vecs[i].e_om));
      check($sformatf("vec%0d count", i), 32'(d_count), 32'(vecs[i].e_cnt));
    end

    // asynchronous reset between edges with six bits held
    @(negedge clk);
    d_in_val = 1'b1; d_in_msg = 3'b111; d_out_rdy = 1'b0; d_flush = 1'b0;
    @(negedge clk);
    @(negedge clk);
    d_in_val = 1'b0;
    #1;
    check("pre-reset count", 32'(d_count), 32'd6);
    check("pre-reset out_val", 32'(d_out_val), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset out_val", 32'(d_out_val), 32'd0);
    check("midreset in_rdy", 32'(d_in_rdy), 32'd1);
    check("midreset count", 32'(d_count), 32'd0);
    check("midreset out_msg", 32'(d_out_msg), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    d_in_val = 1'b1; d_in_msg = 3'b011;
    @(negedge clk);
    d_in_val = 1'b0;
    #1;
    check("post-reset out_msg", 32'(d_out_msg), 32'h3);
    check("post-reset count", 32'(d_count), 32'd3);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    go = 1'b1;
    begin
      int waited;
      waited = 0;
      while (!(g_rand[0].done && g_rand[1].done && g_rand[2].done) && waited < 3000) begin
        @(negedge clk);
        waited++;
      end
      check("random runs completed", 32'(g_rand[0].done && g_rand[1].done && g_rand[2].done), 32'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stream_gearbox.md
# stream_gearbox

Parametrised streaming width converter with latency-insensitive val/rdy handshakes on both sides. It accepts IN_NBITS-bit words, packs them LSB-first into an internal bit buffer, and emits OUT_NBITS-bit words. A flush request drains a trailing partial word, zero-padded. It sits between producers and consumers whose native word widths differ, replacing fixed combinational wire regroupings where the total bit count or the lane sizes do not line up.

## Interface
- IN_NBITS, 3, input word width (>= 1)
- OUT_NBITS, 4, output word width (>= 1)
- BUF_NBITS, IN_NBITS+OUT_NBITS, buffer capacity in bits (must be >= IN_NBITS+OUT_NBITS)
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  asynchronous, active-low; clears all state immediately
- in_val  input  1  producer word valid
- in_rdy  output  1  block can accept input word this cycle
- in_msg  input  IN_NBITS  input word
- out_val  output  1  output word valid
- out_rdy  input  1  consumer accepts output word this cycle
- out_msg  output  OUT_NBITS  output word
- flush  input  1  single-cycle pulse: drain buffered bits including a final partial word
- count  output  clog2(BUF_NBITS+1)  number of valid bits held (debug/verification)

## Operation
- State: buf (BUF_NBITS bits, valid bits right-aligned at [count-1:0]), count, flush_pend.
- Bit order LSB-first: bit 0 of the first accepted input word becomes bit 0 of the first output word; each later input word's bits follow, appended above the existing ones.
- out_val = (count >= OUT_NBITS) | (flush_pend & count != 0).
- out_msg = buf[OUT_NBITS-1:0], with bit positions >= count forced to 0 (zero padding on the flushed partial word).
- deq = out_val & out_rdy; deq_bits = min(count, OUT_NBITS).
- in_rdy = !flush_pend & (count - (deq ? deq_bits : 0) + IN_NBITS <= BUF_NBITS).
- enq = in_val & in_rdy.
- Update order within a cycle: first shift buf right by deq_bits if deq, then write in_msg at bit position (count - deq_bits), then count_next = count - deq_bits + (enq ? IN_NBITS : 0).
- flush = 1 sets flush_pend. flush_pend clears on the edge where count_next == 0. If count == 0 when flush arrives, flush_pend never sets.
- While flush_pend is set, input is blocked: in_rdy = 0.
- Full words ahead of the partial word drain normally during a flush. Only the last word is padded.
- in_val with in_rdy = 0 has no effect, and in_msg is ignored.
- count never exceeds BUF_NBITS, and count never underflows.

## Timing
- Reset (reset = 0, asynchronous): count = 0, buf = 0, flush_pend = 0, hence out_val = 0, in_rdy = 1, out_msg = 0. Reset applied mid-stream discards all buffered bits.
- Latency: bits accepted on edge t are visible on out_msg in cycle t+1. No combinational path exists from in_val/in_msg to the outputs.
- Combinational path out_rdy -> in_rdy exists by design, so input and output can transfer in the same cycle even when the buffer is full.
- Throughput: for IN_NBITS <= OUT_NBITS with out_rdy held high, in_rdy never deasserts, giving 1 input word per cycle. For IN_NBITS > OUT_NBITS, 1 output word per cycle while count >= OUT_NBITS.
- Handshake rules:
  - out_msg and out_val are stable while out_val = 1 and out_rdy = 0, unless flush arrives, which may only add padding visibility, never change already-valid full words.
  - out_val does not depend on out_rdy.
- flush in the same cycle as an enq: the word is accepted first, then flush_pend sets.

## Test plan
- Reset/idle (3->4): release reset, drive nothing -> out_val = 0, in_rdy = 1, count = 0 for 5 cycles.
- Packing (3->4): out_rdy = 1; push 3'b101, 3'b011, 3'b110, 3'b001 on back-to-back cycles -> outputs 4'hd, 4'h9, 4'h3 in order, in_rdy stays 1 throughout, final count = 0.
- Flush (3->4): push 3'b101, pulse flush with out_rdy = 0 -> in_rdy = 0, out_val = 1, out_msg = 4'b0101. Raise out_rdy -> word consumed, count = 0, flush_pend cleared, in_rdy = 1.
- Backpressure (3->4): out_rdy = 0, in_val = 1 with 3'b111 -> two words accepted (count = 6), then in_rdy = 0, out_msg = 4'hf held stable. Raise out_rdy -> simultaneous deq and enq that cycle, count = 5.
- Reset mid-stream: with count = 6 and out_val = 1, assert reset asynchronously between clock edges -> out_val = 0, in_rdy = 1, count = 0 before the next edge. The next stream must pack from bit 0.
- Parametrised randomized run (configs 5->3, 8->8, 3->16): random in_val/out_rdy/flush -> output bit stream equals the input bit stream concatenated LSB-first, with zero-padded partial words only at flush points.
